// File: rtl/serial_add_pkg.sv
// Shared types and constants for the byte-serial add/subtract controller.
//   state_e  : controller FSM states
//   OP_ADD / OP_SUB : req_op encodings
//   get_byte / put_byte : index-driven byte muxes over a 32-bit word
package serial_add_pkg;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = NBYTES * BYTE_W;
  localparam int unsigned IDX_W  = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Select one byte of a word by index.
  function automatic logic [BYTE_W-1:0] get_byte(input logic [DATA_W-1:0] w,
                                                 input logic [IDX_W-1:0]  idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Replace one byte of a word by index, keeping the others.
  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                 input logic [IDX_W-1:0]  idx,
                                                 input logic [BYTE_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_adder.sv
// 8-bit combinational adder shared by all byte slices.
//   in0, in1 : byte operands
//   cin      : carry-in
//   sum      : byte sum
//   cout     : carry-out of bit 7
module byte_adder
  import serial_add_pkg::*;
(
  input  logic [BYTE_W-1:0] in0,
  input  logic [BYTE_W-1:0] in1,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] full;

  assign full = {1'b0, in0} + {1'b0, in1} + {{BYTE_W{1'b0}}, cin};
  assign sum  = full[BYTE_W-1:0];
  assign cout = full[BYTE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Byte-serial 32-bit add/subtract controller with valid/ready handshakes.
// One byte is computed per cycle through a single shared byte_adder.
//   clk, reset_n          : clock, async active-low reset
//   req_val/req_rdy       : request handshake
//   req_op, req_a, req_b  : operation (0 add, 1 a-b) and operands
//   req_cin               : carry-in for add (ignored for subtract)
//   resp_val/resp_rdy     : response handshake
//   resp_sum, resp_cout   : result and carry-out (subtract: 1 = no borrow)
module serial_add_ctrl
  import serial_add_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_cin,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [DATA_W-1:0] resp_sum,
  output logic              resp_cout
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               fin_q, fin_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               rdy_q, rdy_d;
  logic               val_q, val_d;

  logic [BYTE_W-1:0]  add_in0_c, add_in1_c, add_sum_c;
  logic               add_cout_c;

  // Operand byte muxes steered by the index register.
  assign add_in0_c = get_byte(a_q, idx_q);
  assign add_in1_c = get_byte(b_q, idx_q);

  byte_adder u_byte_adder (
    .in0  (add_in0_c),
    .in1  (add_in1_c),
    .cin  (carry_q),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  // Next-state and datapath update.
  // After the byte-3 edge, fin_q marks one settle edge in CALC so that
  // DONE is entered on the fifth edge after acceptance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    fin_d   = fin_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    rdy_d   = rdy_q;
    val_d   = val_q;

    unique case (state_q)
      IDLE: begin
        if (req_val && rdy_q) begin
          state_d = CALC;
          a_d     = req_a;
          b_d     = (req_op == OP_SUB) ? ~req_b : req_b;
          carry_d = (req_op == OP_SUB) ? 1'b1 : req_cin;
          idx_d   = '0;
          fin_d   = 1'b0;
          sum_d   = '0;
          rdy_d   = 1'b0;
        end
      end

      CALC: begin
        if (!fin_q) begin
          sum_d   = put_byte(sum_q, idx_q, add_sum_c);
          carry_d = add_cout_c;
          if (idx_q == IDX_W'(NBYTES - 1)) begin
            // Index stays at 3: it never wraps inside an operation.
            cout_d = add_cout_c;
            fin_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = DONE;
          fin_d   = 1'b0;
          val_d   = 1'b1;
        end
      end

      DONE: begin
        // Requests are not looked at here, so none is taken on the consume edge.
        if (val_q && resp_rdy) begin
          state_d = IDLE;
          val_d   = 1'b0;
          rdy_d   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        val_d   = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      fin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      rdy_q   <= 1'b1;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      fin_q   <= fin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
    end
  end

  assign req_rdy   = rdy_q;
  assign resp_val  = val_q;
  assign resp_sum  = sum_q;
  assign resp_cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl.
module tb_serial_add_ctrl;

  logic        clk;
  logic        reset_n;
  logic        req_val;
  logic        req_rdy;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_cin;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_sum;
  logic        resp_cout;

  int n_test;
  int n_fail;

  serial_add_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_sum  (resp_sum),
    .resp_cout (resp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request, wait (bounded) for acceptance and for the response.
  // Called #1 after a rising edge. wait_n = edges spent waiting for req_rdy,
  // lat = edges from the accepting edge to resp_val (20 means it never came).
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output logic [31:0] sum, output logic cout,
                        output int wait_n, output int lat);
    req_op  = op;
    req_a   = a;
    req_b   = b;
    req_cin = cin;
    req_val = 1'b1;
    wait_n  = 0;
    while (!req_rdy && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    @(posedge clk); #1;
    req_val = 1'b0;
    lat = 0;
    while (!resp_val && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    sum  = resp_sum;
    cout = resp_cout;
  endtask

  task automatic consume();
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_test++;
    if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b expected 1", req_rdy); end
    n_test++;
    if (resp_val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b expected 0", resp_val); end
    n_test++;
    if (resp_sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h expected 00000000", resp_sum); end
    n_test++;
    if (resp_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", resp_cout); end
    reset_n = 1'b1;
  endtask

  task automatic test_add_byte_carry();
    logic [31:0] s; logic c; int w; int lat;
    run_op(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, s, c, w, lat);
    n_test++;
    if (w !== 0) begin n_fail++; $display("FAIL first_edge_accept: waited %0d expected 0", w); end
    n_test++;
    if (lat !== 5) begin n_fail++; $display("FAIL latency_add: got %0d expected 5", lat); end
    n_test++;
    if (s !== 32'h0000_0100) begin n_fail++; $display("FAIL add_ff_1_sum: got %h expected 00000100", s); end
    n_test++;
    if (c !== 1'b0) begin n_fail++; $display("FAIL add_ff_1_cout: got %b expected 0", c); end
    consume();
    n_test++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL consume_to_idle: val %b rdy %b expected 0 1", resp_val, req_rdy);
    end
    n_test++;
    if (resp_sum !== 32'h0000_0100) begin n_fail++; $display("FAIL idle_hold_sum: got %h expected 00000100", resp_sum); end
  endtask

  task automatic test_add_ripple();
    logic [31:0] s; logic c; int w; int lat;
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, s, c, w, lat);
    n_test++;
    if (lat !== 5) begin n_fail++; $display("FAIL latency_ripple: got %0d expected 5", lat); end
    n_test++;
    if (s !== 32'h0000_0000) begin n_fail++; $display("FAIL ripple_sum: got %h expected 00000000", s); end
    n_test++;
    if (c !== 1'b1) begin n_fail++; $display("FAIL ripple_cout: got %b expected 1", c); end
    consume();
  endtask

  task automatic test_sub();
    logic [31:0] s; logic c; int w; int lat;
    run_op(1'b1, 32'd5, 32'd3, 1'b0, s, c, w, lat);
    n_test++;
    if (s !== 32'h0000_0002) begin n_fail++; $display("FAIL sub_5_3_sum: got %h expected 00000002", s); end
    n_test++;
    if (c !== 1'b1) begin n_fail++; $display("FAIL sub_5_3_cout: got %b expected 1", c); end
    consume();
    run_op(1'b1, 32'd3, 32'd5, 1'b1, s, c, w, lat);
    n_test++;
    if (s !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_3_5_sum: got %h expected fffffffe", s); end
    n_test++;
    if (c !== 1'b0) begin n_fail++; $display("FAIL sub_3_5_cout: got %b expected 0", c); end
    consume();
  endtask

  task automatic test_stall();
    logic [31:0] s; logic c; int w; int lat;
    req_op = 1'b0; req_a = 32'h1234_5678; req_b = 32'h1111_1111; req_cin = 1'b0;
    req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin
        req_val = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'h0F0F_0F0F; req_op = 1'b1;
      end
      @(posedge clk); #1;
      req_val = 1'b0;
      if (i < 5) begin
        n_test++;
        if (req_rdy !== 1'b0 || resp_val !== 1'b0) begin
          n_fail++; $display("FAIL calc_handshake edge %0d: rdy %b val %b expected 0 0", i, req_rdy, resp_val);
        end
      end
    end
    n_test++;
    if (resp_val !== 1'b1) begin n_fail++; $display("FAIL stall_val_edge5: got %b expected 1", resp_val); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_test++;
      if (resp_val !== 1'b1 || resp_sum !== 32'h2345_6789 || resp_cout !== 1'b0 || req_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: val %b sum %h cout %b rdy %b expected 1 23456789 0 0",
                 i, resp_val, resp_sum, resp_cout, req_rdy);
      end
    end
    // Consume with a new request already presented: it must not be taken on this edge.
    req_op = 1'b0; req_a = 32'd1; req_b = 32'd2; req_cin = 1'b0; req_val = 1'b1;
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    n_test++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1 || resp_sum !== 32'h2345_6789) begin
      n_fail++;
      $display("FAIL consume_no_accept: val %b rdy %b sum %h expected 0 1 23456789", resp_val, req_rdy, resp_sum);
    end
    run_op(1'b0, 32'd1, 32'd2, 1'b0, s, c, w, lat);
    n_test++;
    if (w !== 0 || lat !== 5 || s !== 32'd3 || c !== 1'b0) begin
      n_fail++; $display("FAIL after_consume_op: wait %0d lat %0d sum %h cout %b expected 0 5 00000003 0", w, lat, s, c);
    end
    consume();
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] s; logic c; int w; int lat; int seen;
    req_op = 1'b0; req_a = 32'hAAAA_AAAA; req_b = 32'h5555_5555; req_cin = 1'b1;
    req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_test++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1 || resp_sum !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_calc: val %b rdy %b sum %h expected 0 1 00000000", resp_val, req_rdy, resp_sum);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_val) seen++;
    end
    n_test++;
    if (seen !== 0) begin n_fail++; $display("FAIL aborted_no_resp: got %0d valid cycles expected 0", seen); end
    run_op(1'b0, 32'd1, 32'd1, 1'b0, s, c, w, lat);
    n_test++;
    if (lat !== 5 || s !== 32'h0000_0002 || c !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_add: lat %0d sum %h cout %b expected 5 00000002 0", lat, s, c);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] s; logic c; int w; int lat;
    logic [31:0] a; logic [31:0] b; logic op; logic cin; logic [32:0] ref_v;
    for (int i = 0; i < 20; i++) begin
      a   = $urandom;
      b   = $urandom;
      op  = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      if (op) ref_v = {1'b0, a} - {1'b0, b} + 33'h1_0000_0000;
      else    ref_v = {1'b0, a} + {1'b0, b} + 33'(cin);
      run_op(op, a, b, cin, s, c, w, lat);
      n_test++;
      if (w !== 0 || lat !== 5 || s !== ref_v[31:0] || c !== ref_v[32]) begin
        n_fail++;
        $display("FAIL b2b[%0d] op %b a %h b %h cin %b: wait %0d lat %0d sum %h cout %b expected 0 5 %h %b",
                 i, op, a, b, cin, w, lat, s, c, ref_v[31:0], ref_v[32]);
      end
      consume();
    end
  endtask

  initial begin
    n_test   = 0;
    n_fail   = 0;
    req_val  = 1'b0;
    req_op   = 1'b0;
    req_a    = '0;
    req_b    = '0;
    req_cin  = 1'b0;
    resp_rdy = 1'b0;
    reset_n  = 1'b0;
    test_reset();
    test_add_byte_carry();
    test_add_ripple();
    test_sub();
    test_stall();
    test_reset_mid_calc();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
